// File: rtl/tx_frame_arb.sv
// Frame-granular two-source round-robin arbiter for the 64-bit XGMII transmit path.
// Zero-latency pass-through, programmable inter-frame gap, max-length truncation with drain.
module tx_frame_arb #(
  parameter int IFG_CYCLES = 2,
  parameter int MAX_WORDS  = 190
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        req0_valid,
  input  logic [63:0] req0_data,
  input  logic [7:0]  req0_keep,
  input  logic        req0_last,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [63:0] req1_data,
  input  logic [7:0]  req1_keep,
  input  logic        req1_last,
  output logic        req1_ready,
  output logic        m_valid,
  output logic [63:0] m_data,
  output logic [7:0]  m_keep,
  output logic        m_last,
  output logic        m_src,
  input  logic        m_ready,
  output logic        busy,
  output logic [15:0] frames0,
  output logic [15:0] frames1,
  output logic [15:0] trunc_cnt
);

  localparam int WCW = $clog2(MAX_WORDS + 1);
  localparam int GW  = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam logic [WCW-1:0] MAXW     = WCW'(MAX_WORDS);
  localparam logic [GW-1:0]  GAP_LOAD = (IFG_CYCLES > 0) ? GW'(IFG_CYCLES - 1) : GW'(0);

  typedef enum logic [1:0] {IDLE, XFER, DRAIN, GAP} state_t;

  state_t         state_q, state_d;
  logic           grant_q, grant_d;
  logic           pref_q, pref_d;
  logic [WCW-1:0] word_q, word_d;
  logic [GW-1:0]  gap_q, gap_d;
  logic [15:0]    frames0_q, frames0_d;
  logic [15:0]    frames1_q, frames1_d;
  logic [15:0]    trunc_q, trunc_d;

  logic        sel_valid, sel_last, forced, fin, sel_ready;
  logic [63:0] sel_data;
  logic [7:0]  sel_keep;

  assign sel_valid = grant_q ? req1_valid : req0_valid;
  assign sel_data  = grant_q ? req1_data  : req0_data;
  assign sel_keep  = grant_q ? req1_keep  : req0_keep;
  assign sel_last  = grant_q ? req1_last  : req0_last;
  assign forced    = (word_q == MAXW);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    pref_d    = pref_q;
    word_d    = word_q;
    gap_d     = gap_q;
    frames0_d = frames0_q;
    frames1_d = frames1_q;
    trunc_d   = trunc_q;
    m_valid   = 1'b0;
    m_data    = '0;
    m_keep    = '0;
    m_last    = 1'b0;
    sel_ready = 1'b0;
    fin       = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable && (req0_valid || req1_valid)) begin
          grant_d = (req0_valid && req1_valid) ? pref_q : req1_valid;
          pref_d  = ~grant_d;
          word_d  = WCW'(1);
          state_d = XFER;
        end
      end
      XFER: begin
        m_valid   = sel_valid;
        m_data    = sel_data;
        m_keep    = sel_keep;
        m_last    = sel_last | forced;
        sel_ready = m_ready;
        if (sel_valid && m_ready) begin
          word_d = word_q + 1'b1;
          if (sel_last || forced) begin
            if (grant_q) frames1_d = frames1_q + 16'd1;
            else         frames0_d = frames0_q + 16'd1;
            if (sel_last) begin
              fin = 1'b1;
            end else begin
              // Downstream already saw a closed frame; swallow the source's tail.
              trunc_d = trunc_q + 16'd1;
              state_d = DRAIN;
            end
          end
        end
      end
      DRAIN: begin
        sel_ready = 1'b1;
        if (sel_valid && sel_last) fin = 1'b1;
      end
      GAP: begin
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (fin) begin
      state_d = (IFG_CYCLES == 0) ? IDLE : GAP;
      gap_d   = GAP_LOAD;
    end

    req0_ready = sel_ready & ~grant_q;
    req1_ready = sel_ready &  grant_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= 1'b0;
      pref_q    <= 1'b0;
      word_q    <= '0;
      gap_q     <= '0;
      frames0_q <= '0;
      frames1_q <= '0;
      trunc_q   <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      pref_q    <= pref_d;
      word_q    <= word_d;
      gap_q     <= gap_d;
      frames0_q <= frames0_d;
      frames1_q <= frames1_d;
      trunc_q   <= trunc_d;
    end
  end

  assign m_src     = grant_q;
  assign busy      = (state_q != IDLE);
  assign frames0   = frames0_q;
  assign frames1   = frames1_q;
  assign trunc_cnt = trunc_q;

endmodule

// File: tb/tb_tx_frame_arb.sv
// Bench for tx_frame_arb: directed scenarios plus a randomized run against a frame-queue model.
module tb_tx_frame_arb;

  localparam int IFG  = 2;
  localparam int MAXW = 190;

  logic        clk = 1'b0, rst = 1'b1, enable = 1'b0;
  logic        req0_valid, req0_last, req0_ready, req1_valid, req1_last, req1_ready;
  logic [63:0] req0_data, req1_data, m_data;
  logic [7:0]  req0_keep, req1_keep, m_keep;
  logic        m_valid, m_last, m_src, m_ready = 1'b0, busy;
  logic [15:0] frames0, frames1, trunc_cnt;

  int n_chk = 0, n_fail = 0;

  typedef struct packed { logic [63:0] d; logic [7:0] k; logic l; } beat_t;
  beat_t sq0[$], sq1[$], eq0[$], eq1[$];
  int nf0, nf1, ntr;

  tx_frame_arb #(.IFG_CYCLES(IFG), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_keep(req0_keep),
    .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_keep(req1_keep),
    .req1_last(req1_last), .req1_ready(req1_ready),
    .m_valid(m_valid), .m_data(m_data), .m_keep(m_keep), .m_last(m_last),
    .m_src(m_src), .m_ready(m_ready), .busy(busy),
    .frames0(frames0), .frames1(frames1), .trunc_cnt(trunc_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    req0_valid = 0; req0_data = '0; req0_keep = '0; req0_last = 0;
    req1_valid = 0; req1_data = '0; req1_keep = '0; req1_last = 0;
  endtask

  task automatic reset_dut();
    idle_in();
    m_ready = 0; enable = 1; rst = 1;
    tick();
    rst = 0;
    tick();
  endtask

  task automatic gen(input int s, input int len);
    beat_t b;
    for (int j = 0; j < len; j++) begin
      b.d = {$urandom, $urandom};
      b.l = (j == len - 1);
      b.k = b.l ? 8'($urandom_range(1, 255)) : 8'hFF;
      if (s == 0) sq0.push_back(b); else sq1.push_back(b);
      if (j < MAXW) begin
        if (j == MAXW - 1) b.l = 1'b1;
        if (s == 0) eq0.push_back(b); else eq1.push_back(b);
      end
    end
    if (len > MAXW) ntr++;
    if (s == 0) nf0++; else nf1++;
  endtask

  task automatic test_reset();
    idle_in(); rst = 1; #1;
    n_chk++;
    if ({m_valid, m_data, m_keep, m_last, m_src, req0_ready, req1_ready, busy, frames0, frames1, trunc_cnt} !== '0) begin
      n_fail++; $display("FAIL reset_state: got v=%b d=%h k=%h l=%b src=%b busy=%b f0=%0d f1=%0d tr=%0d expected all zero",
        m_valid, m_data, m_keep, m_last, m_src, busy, frames0, frames1, trunc_cnt);
    end
    tick(); rst = 0; tick(); #1;
    n_chk++;
    if ({busy, m_valid} !== 2'b00) begin n_fail++; $display("FAIL reset_idle: got busy=%b v=%b expected 0 0", busy, m_valid); end
  endtask

  task automatic test_single();
    logic [63:0] d [3];
    logic [7:0] k;
    reset_dut(); m_ready = 1;
    for (int b = 0; b < 3; b++) d[b] = {$urandom, $urandom};
    req0_valid = 1; req0_data = d[0]; req0_keep = 8'hFF; req0_last = 0; #1;
    n_chk++;
    if ({m_valid, req0_ready} !== 2'b00) begin n_fail++; $display("FAIL single_idle: got v=%b rdy=%b expected 0 0", m_valid, req0_ready); end
    tick();
    for (int b = 0; b < 3; b++) begin
      k = (b == 2) ? 8'h0F : 8'hFF;
      req0_data = d[b]; req0_keep = k; req0_last = (b == 2); #1;
      n_chk++;
      if ({m_valid, m_data, m_keep, m_last, m_src, req0_ready} !== {1'b1, d[b], k, (b == 2), 1'b0, 1'b1}) begin
        n_fail++; $display("FAIL single_beat%0d: got v=%b d=%h k=%h l=%b src=%b rdy=%b expected 1 %h %h %b 0 1",
          b, m_valid, m_data, m_keep, m_last, m_src, req0_ready, d[b], k, (b == 2));
      end
      tick();
    end
    idle_in(); #1;
    n_chk++;
    if ({frames0, frames1, busy, m_valid} !== {16'd1, 16'd0, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL single_count: got f0=%0d f1=%0d busy=%b v=%b expected 1 0 1 0", frames0, frames1, busy, m_valid);
    end
  endtask

  task automatic test_round_robin();
    int b0, b1, nfr, last_cyc, cyc;
    logic first;
    logic [3:0] seq;
    reset_dut(); m_ready = 1;
    b0 = 0; b1 = 0; nfr = 0; last_cyc = -100; first = 1; seq = '0;
    for (cyc = 0; cyc < 80 && nfr < 4; cyc++) begin
      req0_valid = 1; req0_last = (b0 == 1); req0_data = {32'h0, 32'(b0)}; req0_keep = 8'hFF;
      req1_valid = 1; req1_last = (b1 == 1); req1_data = {32'h1, 32'(b1)}; req1_keep = 8'hFF;
      #1;
      if (m_valid && m_ready) begin
        if (first) begin
          seq[nfr] = m_src;
          if (nfr > 0) begin
            n_chk++;
            if ((cyc - last_cyc) !== IFG + 2) begin n_fail++; $display("FAIL rr_gap%0d: got %0d cycles last-to-first expected %0d", nfr, cyc - last_cyc, IFG + 2); end
          end
          first = 0;
        end
        if (m_last) begin last_cyc = cyc; nfr++; first = 1; end
      end
      if (req0_valid && req0_ready) b0 = 1 - b0;
      if (req1_valid && req1_ready) b1 = 1 - b1;
      tick();
    end
    idle_in();
    n_chk++;
    if ({nfr[3:0], seq} !== {4'd4, 4'b1010}) begin n_fail++; $display("FAIL rr_order: got frames=%0d seq=%b expected 4 1010", nfr, seq); end
    n_chk++;
    if ({frames0, frames1} !== {16'd2, 16'd2}) begin n_fail++; $display("FAIL rr_counts: got f0=%0d f1=%0d expected 2 2", frames0, frames1); end
  endtask

  task automatic test_backpressure();
    logic [63:0] d [4];
    int i, o;
    reset_dut();
    for (int b = 0; b < 4; b++) d[b] = {$urandom, $urandom};
    i = 0; o = 0;
    for (int cyc = 0; cyc < 40 && i < 4; cyc++) begin
      req0_valid = 1; req0_data = d[i]; req0_keep = 8'hFF; req0_last = (i == 3);
      m_ready = (cyc % 2 == 0);
      #1;
      if (busy) begin
        n_chk++;
        if ({req0_ready, req1_ready} !== {m_ready, 1'b0}) begin n_fail++; $display("FAIL bp_ready: got r0=%b r1=%b expected %b 0", req0_ready, req1_ready, m_ready); end
      end
      if (m_valid && m_ready) begin
        n_chk++;
        if (m_data !== d[o]) begin n_fail++; $display("FAIL bp_data%0d: got %h expected %h", o, m_data, d[o]); end
        o++;
      end
      if (req0_valid && req0_ready) i++;
      tick();
    end
    idle_in();
    n_chk++;
    if ({i[7:0], o[7:0], frames0} !== {8'd4, 8'd4, 16'd1}) begin n_fail++; $display("FAIL bp_totals: got in=%0d out=%0d f0=%0d expected 4 4 1", i, o, frames0); end
  endtask

  task automatic test_overlength();
    int i, o, dr;
    reset_dut(); m_ready = 1;
    i = 0; o = 0; dr = 0;
    for (int cyc = 0; cyc < 400 && i < MAXW + 5; cyc++) begin
      req1_valid = 1; req1_data = {32'hA5A50001, 32'(i)}; req1_keep = 8'hFF; req1_last = (i == MAXW + 4);
      #1;
      if (m_valid && m_ready) begin
        o++;
        n_chk++;
        if ({m_src, m_last, m_data} !== {1'b1, (o == MAXW), 32'hA5A50001, 32'(o - 1)}) begin
          n_fail++; $display("FAIL ovl_beat%0d: got src=%b last=%b d=%h expected 1 %b %h", o, m_src, m_last, m_data, (o == MAXW), {32'hA5A50001, 32'(o - 1)});
        end
      end
      if (busy && !m_valid && req1_ready) dr++;
      if (req1_valid && req1_ready) i++;
      tick();
    end
    idle_in();
    n_chk++;
    if ({o[15:0], dr[7:0], trunc_cnt, frames1, frames0} !== {16'(MAXW), 8'd5, 16'd1, 16'd1, 16'd0}) begin
      n_fail++; $display("FAIL ovl_totals: got out=%0d drained=%0d tr=%0d f1=%0d f0=%0d expected %0d 5 1 1 0", o, dr, trunc_cnt, frames1, frames0, MAXW);
    end
  endtask

  task automatic test_enable();
    int i, o;
    reset_dut(); m_ready = 1;
    i = 0; o = 0;
    for (int cyc = 0; cyc < 30 && i < 4; cyc++) begin
      req0_valid = 1; req0_data = 64'(i) + 64'h7700; req0_keep = 8'hFF; req0_last = (i == 3);
      req1_valid = 1; req1_data = 64'hBEEF; req1_keep = 8'hFF; req1_last = 1;
      if (i >= 1) enable = 0;
      #1;
      if (m_valid && m_ready) begin
        n_chk++;
        if ({m_src, m_data} !== {1'b0, 64'(o) + 64'h7700}) begin n_fail++; $display("FAIL en_beat%0d: got src=%b d=%h expected 0 %h", o, m_src, m_data, 64'(o) + 64'h7700); end
        o++;
      end
      if (req0_valid && req0_ready) i++;
      tick();
    end
    req0_valid = 0;
    n_chk++;
    if ({o[7:0], frames0} !== {8'd4, 16'd1}) begin n_fail++; $display("FAIL en_finish: got out=%0d f0=%0d expected 4 1", o, frames0); end
    for (int c = 0; c < 10; c++) begin
      #1;
      n_chk++;
      if ({m_valid, req1_ready} !== 2'b00) begin n_fail++; $display("FAIL en_hold%0d: got v=%b r1=%b expected 0 0", c, m_valid, req1_ready); end
      tick();
    end
    n_chk++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL en_idle: got busy=%b expected 0", busy); end
    enable = 1;
    tick(); #1;
    n_chk++;
    if ({busy, m_src, m_valid} !== 3'b111) begin n_fail++; $display("FAIL en_regrant: got busy=%b src=%b v=%b expected 1 1 1", busy, m_src, m_valid); end
    idle_in(); m_ready = 0;
  endtask

  task automatic test_reset_mid();
    reset_dut(); m_ready = 1;
    req1_valid = 1; req1_data = 64'h1111; req1_keep = 8'hFF; req1_last = 0;
    tick(); #1;
    n_chk++;
    if ({m_valid, m_src} !== 2'b11) begin n_fail++; $display("FAIL rstmid_grant: got v=%b src=%b expected 1 1", m_valid, m_src); end
    tick();
    rst = 1; #1;
    n_chk++;
    if ({m_valid, m_data, m_keep, m_last, m_src, req0_ready, req1_ready, busy, frames0, frames1, trunc_cnt} !== '0) begin
      n_fail++; $display("FAIL rstmid_outputs: got v=%b d=%h src=%b r1=%b busy=%b expected all zero", m_valid, m_data, m_src, req1_ready, busy);
    end
    rst = 0;
    req0_valid = 1; req0_data = 64'h2222; req0_keep = 8'hFF; req0_last = 1;
    tick(); #1;
    n_chk++;
    if ({m_valid, m_src, m_data} !== {1'b1, 1'b0, 64'h2222}) begin n_fail++; $display("FAIL rstmid_first: got v=%b src=%b d=%h expected 1 0 2222", m_valid, m_src, m_data); end
    idle_in(); m_ready = 0;
  endtask

  task automatic test_random();
    beat_t b, e;
    logic pref, gexp, gpend, first;
    int last_cyc, cyc, len, s;
    reset_dut();
    sq0.delete(); sq1.delete(); eq0.delete(); eq1.delete();
    nf0 = 0; nf1 = 0; ntr = 0;
    for (int f = 0; f < 40; f++) begin
      s = $urandom_range(0, 1);
      len = ($urandom_range(0, 9) == 0) ? $urandom_range(MAXW - 1, MAXW + 6) : $urandom_range(1, 6);
      gen(s, len);
    end
    pref = 0; gpend = 0; first = 1; last_cyc = -100;
    for (cyc = 0; cyc < 20000 && (sq0.size() + sq1.size() + eq0.size() + eq1.size()) > 0; cyc++) begin
      enable  = ($urandom_range(0, 7) != 0);
      m_ready = ($urandom_range(0, 3) != 0);
      if (sq0.size() > 0) begin req0_valid = ($urandom_range(0, 3) != 0); {req0_data, req0_keep, req0_last} = sq0[0]; end
      else begin req0_valid = 0; req0_data = '0; req0_keep = '0; req0_last = 0; end
      if (sq1.size() > 0) begin req1_valid = ($urandom_range(0, 3) != 0); {req1_data, req1_keep, req1_last} = sq1[0]; end
      else begin req1_valid = 0; req1_data = '0; req1_keep = '0; req1_last = 0; end
      #1;
      if (gpend) begin
        n_chk++;
        if ({busy, m_src} !== {1'b1, gexp}) begin n_fail++; $display("FAIL rnd_grant@%0d: got busy=%b src=%b expected 1 %b", cyc, busy, m_src, gexp); end
        gpend = 0;
      end
      if (!busy) begin
        n_chk++;
        if ({m_valid, req0_ready, req1_ready} !== 3'b000) begin n_fail++; $display("FAIL rnd_idle@%0d: got v=%b r0=%b r1=%b expected 0 0 0", cyc, m_valid, req0_ready, req1_ready); end
        if (enable && (req0_valid || req1_valid)) begin
          gexp = (req0_valid && req1_valid) ? pref : req1_valid;
          pref = ~gexp; gpend = 1;
        end
      end
      if (m_valid && m_ready) begin
        n_chk++;
        if ((m_src ? req1_ready : req0_ready) !== 1'b1) begin n_fail++; $display("FAIL rnd_passthru@%0d: got src ready 0 expected 1", cyc); end
        if (m_src ? (eq1.size() == 0) : (eq0.size() == 0)) begin
          n_chk++; n_fail++; $display("FAIL rnd_extra@%0d: got unexpected beat d=%h from src %b expected none", cyc, m_data, m_src);
        end else begin
          e = m_src ? eq1.pop_front() : eq0.pop_front();
          n_chk++;
          if ({m_data, m_keep, m_last} !== e) begin n_fail++; $display("FAIL rnd_beat@%0d: got %h/%h/%b expected %h/%h/%b", cyc, m_data, m_keep, m_last, e.d, e.k, e.l); end
        end
        if (first) begin
          n_chk++;
          if ((cyc - last_cyc) < IFG + 2) begin n_fail++; $display("FAIL rnd_gap@%0d: got %0d cycles expected >= %0d", cyc, cyc - last_cyc, IFG + 2); end
          first = 0;
        end
        if (m_last) first = 1;
      end
      if (req0_valid && req0_ready) begin if (req0_last) last_cyc = cyc; b = sq0.pop_front(); end
      if (req1_valid && req1_ready) begin if (req1_last) last_cyc = cyc; b = sq1.pop_front(); end
      tick();
    end
    idle_in();
    n_chk++;
    if ((sq0.size() + sq1.size() + eq0.size() + eq1.size()) != 0) begin
      n_fail++; $display("FAIL rnd_timeout: got %0d beats outstanding expected 0", sq0.size() + sq1.size() + eq0.size() + eq1.size());
    end
    n_chk++;
    if ({frames0, frames1, trunc_cnt} !== {16'(nf0), 16'(nf1), 16'(ntr)}) begin
      n_fail++; $display("FAIL rnd_counters: got f0=%0d f1=%0d tr=%0d expected %0d %0d %0d", frames0, frames1, trunc_cnt, nf0, nf1, ntr);
    end
  endtask

  initial begin
    idle_in();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_overlength();
    test_enable();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
